// File: rtl/bob_retire_pkg.sv
// Shared constants and types for the branch order buffer retire path.
package bob_retire_pkg;
    localparam int BOB_COUNT   = 48;
    localparam int ADDR_WIDTH  = 6;
    localparam int BOB_WIDTH   = 40;
    localparam int DATA_WIDTH  = BOB_WIDTH;
    localparam int BOB_MIS_BIT = BOB_WIDTH - 1;

    typedef struct packed {
        logic                  en;
        logic [ADDR_WIDTH-1:0] addr;
        logic                  mis;
    } wb_port_t;

    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return a < ADDR_WIDTH'(BOB_COUNT);
    endfunction
endpackage

// File: rtl/bob_done_tbl.sv
// Per-entry done/mispredict bitmaps with two set ports, one clear port and flash clear.
module bob_done_tbl
    import bob_retire_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flash_clr,
    input  wb_port_t              set0,
    input  wb_port_t              set1,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_addr,
    output logic [BOB_COUNT-1:0]  done_vec,
    output logic [BOB_COUNT-1:0]  mis_vec
);
    logic [BOB_COUNT-1:0] done_r;
    logic [BOB_COUNT-1:0] mis_r;
    logic [BOB_COUNT-1:0] set_s;
    logic [BOB_COUNT-1:0] set_mis_s;

    // Decode both writeback ports; same-entry hits OR their mispredict flags.
    always_comb begin
        set_s     = '0;
        set_mis_s = '0;
        for (int i = 0; i < BOB_COUNT; i++) begin
            set_s[i]     = (set0.en && set0.addr == ADDR_WIDTH'(i)) ||
                           (set1.en && set1.addr == ADDR_WIDTH'(i));
            set_mis_s[i] = (set0.en && set0.addr == ADDR_WIDTH'(i) && set0.mis) ||
                           (set1.en && set1.addr == ADDR_WIDTH'(i) && set1.mis);
        end
    end

    // Flash clear beats retire clear, which beats writeback set.
    always_ff @(posedge clk) begin
        if (rst || flash_clr) begin
            done_r <= '0;
            mis_r  <= '0;
        end else begin
            for (int i = 0; i < BOB_COUNT; i++) begin
                if (clr_en && clr_addr == ADDR_WIDTH'(i)) begin
                    done_r[i] <= 1'b0;
                    mis_r[i]  <= 1'b0;
                end else if (set_s[i]) begin
                    done_r[i] <= 1'b1;
                    mis_r[i]  <= set_mis_s[i];
                end else begin
                    done_r[i] <= done_r[i];
                    mis_r[i]  <= mis_r[i];
                end
            end
        end
    end

    assign done_vec = done_r;
    assign mis_vec  = mis_r;
endmodule

// File: rtl/bob_retire_chk.sv
// Protocol checks for the retire path: no writeback may target the head being retired.
module bob_retire_chk
    import bob_retire_pkg::*;
(
    input logic                  clk,
    input logic                  rst,
    input logic                  go,
    input logic [ADDR_WIDTH-1:0] retire_addr,
    input logic                  done0_en,
    input logic [ADDR_WIDTH-1:0] done0_addr,
    input logic                  done1_en,
    input logic [ADDR_WIDTH-1:0] done1_addr
);
    // A completed head cannot legally be written back again in its retire cycle.
    always @(posedge clk) begin
        if (!rst && go) begin
            assert (!((done0_en && done0_addr == retire_addr) ||
                      (done1_en && done1_addr == retire_addr)))
            else $error("bob_retire_chk: writeback to head during retire, addr %0d", retire_addr);
        end
    end
endmodule

// File: rtl/bob_retire.sv
// In-order retire reader for the branch order buffer: issues head reads, presents
// retired entries one cycle later and raises flush on a retired mispredict.
module bob_retire
    import bob_retire_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  except_in,
    input  logic                  hasRetire,
    input  logic [ADDR_WIDTH-1:0] retire_addr,
    output logic                  doRetire,
    output logic                  ram_read_clkEn,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    input  logic [DATA_WIDTH-1:0] ram_read_data,
    input  logic                  done0_en,
    input  logic [ADDR_WIDTH-1:0] done0_addr,
    input  logic                  done0_mispred,
    input  logic                  done1_en,
    input  logic [ADDR_WIDTH-1:0] done1_addr,
    input  logic                  done1_mispred,
    input  logic                  ret_stall,
    output logic                  ret_valid,
    output logic [ADDR_WIDTH-1:0] ret_addr,
    output logic [DATA_WIDTH-1:0] ret_data,
    output logic                  ret_mispred,
    output logic                  flush
);
    logic [BOB_COUNT-1:0]  done_vec_s;
    logic [BOB_COUNT-1:0]  mis_vec_s;
    logic                  done_head_s;
    logic                  mis_head_s;
    logic                  kill_s;
    logic                  go_s;
    logic                  s1_valid_r;
    logic [ADDR_WIDTH-1:0] s1_addr_r;
    logic                  s1_mis_r;

    bob_done_tbl u_tbl (
        .clk      (clk),
        .rst      (rst),
        .flash_clr(kill_s),
        .set0     ('{en: done0_en, addr: done0_addr, mis: done0_mispred}),
        .set1     ('{en: done1_en, addr: done1_addr, mis: done1_mispred}),
        .clr_en   (go_s),
        .clr_addr (retire_addr),
        .done_vec (done_vec_s),
        .mis_vec  (mis_vec_s)
    );

    bob_retire_chk u_chk (
        .clk        (clk),
        .rst        (rst),
        .go         (go_s),
        .retire_addr(retire_addr),
        .done0_en   (done0_en),
        .done0_addr (done0_addr),
        .done1_en   (done1_en),
        .done1_addr (done1_addr)
    );

    // Look up the head entry's status; out-of-range heads are never done.
    always_comb begin
        done_head_s = 1'b0;
        mis_head_s  = 1'b0;
        if (addr_ok(retire_addr)) begin
            done_head_s = done_vec_s[retire_addr];
            mis_head_s  = mis_vec_s[retire_addr];
        end else begin
            done_head_s = 1'b0;
            mis_head_s  = 1'b0;
        end
    end

    assign flush          = s1_valid_r & s1_mis_r;
    assign kill_s         = flush | except_in;
    assign go_s           = hasRetire & done_head_s & ~ret_stall & ~kill_s;
    assign doRetire       = go_s;
    assign ram_read_clkEn = go_s;
    assign ram_read_addr  = retire_addr;

    // Stage-1 register: valid for exactly one cycle per issued retire.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_addr_r  <= '0;
            s1_mis_r   <= 1'b0;
        end else if (go_s) begin
            s1_valid_r <= 1'b1;
            s1_addr_r  <= retire_addr;
            s1_mis_r   <= mis_head_s;
        end else begin
            s1_valid_r <= 1'b0;
            s1_addr_r  <= s1_addr_r;
            s1_mis_r   <= s1_mis_r;
        end
    end

    assign ret_valid   = s1_valid_r;
    assign ret_addr    = s1_addr_r;
    assign ret_mispred = s1_mis_r;
    assign ret_data    = s1_valid_r ? ram_read_data : '0;
endmodule

// File: tb/tb_bob_retire.sv
// Scoreboard bench for bob_retire: a queue-based allocator/BOB model predicts
// retires; a separate monitor checks every presented entry.
module tb_bob_retire;
    import bob_retire_pkg::*;

    logic                  clk, rst, except_in, hasRetire;
    logic [ADDR_WIDTH-1:0] retire_addr, ram_read_addr, done0_addr, done1_addr, ret_addr;
    logic                  doRetire, ram_read_clkEn;
    logic [DATA_WIDTH-1:0] ram_read_data, ret_data;
    logic                  done0_en, done0_mispred, done1_en, done1_mispred;
    logic                  ret_stall, ret_valid, ret_mispred, flush;

    bob_retire dut (
        .clk(clk), .rst(rst), .except_in(except_in), .hasRetire(hasRetire),
        .retire_addr(retire_addr), .doRetire(doRetire), .ram_read_clkEn(ram_read_clkEn),
        .ram_read_addr(ram_read_addr), .ram_read_data(ram_read_data),
        .done0_en(done0_en), .done0_addr(done0_addr), .done0_mispred(done0_mispred),
        .done1_en(done1_en), .done1_addr(done1_addr), .done1_mispred(done1_mispred),
        .ret_stall(ret_stall), .ret_valid(ret_valid), .ret_addr(ret_addr),
        .ret_data(ret_data), .ret_mispred(ret_mispred), .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_WIDTH-1:0] mem [BOB_COUNT];
    logic [ADDR_WIDTH-1:0] rd_addr;
    always @(posedge clk) if (ram_read_clkEn) rd_addr <= ram_read_addr;
    assign ram_read_data = (rd_addr < 6'd48) ? mem[rd_addr] : '0;

    typedef struct {
        int                    addr;
        logic [DATA_WIDTH-1:0] data;
        bit                    mis;
        int                    due;
    } exp_t;
    exp_t q[$];

    bit m_done [BOB_COUNT];
    bit m_mis  [BOB_COUNT];
    bit m_s1_valid, m_s1_mis;
    int head, count, cyc, total, bad;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // One clock of stimulus: drive, check issue-side outputs, advance the model.
    task automatic step(input bit w0e, input int w0a, input bit w0m,
                        input bit w1e, input int w1a, input bit w1m,
                        input bit stall, input bit exc);
        bit eflush, ego, hmis;
        #1;
        hasRetire = (count > 0); retire_addr = 6'(head);
        done0_en = w0e; done0_addr = 6'(w0a); done0_mispred = w0m;
        done1_en = w1e; done1_addr = 6'(w1a); done1_mispred = w1m;
        ret_stall = stall; except_in = exc;
        #2;
        eflush = m_s1_valid && m_s1_mis;
        ego = (count > 0) && m_done[head] && !stall && !eflush && !exc;
        chk("doRetire", 64'(doRetire), 64'(ego));
        chk("ram_read_clkEn", 64'(ram_read_clkEn), 64'(ego));
        chk("ram_read_addr", 64'(ram_read_addr), 64'(head));
        chk("flush", 64'(flush), 64'(eflush));
        hmis = m_mis[head];
        if (ego) q.push_back('{addr: head, data: mem[head], mis: hmis, due: cyc + 1});
        if (eflush || exc) begin
            foreach (m_done[i]) begin m_done[i] = 1'b0; m_mis[i] = 1'b0; end
            m_s1_valid = 1'b0;
            count = 0;
        end else begin
            if (w0e && w0a < BOB_COUNT) begin m_done[w0a] = 1'b1; m_mis[w0a] = w0m; end
            if (w1e && w1a < BOB_COUNT) begin
                m_done[w1a] = 1'b1;
                m_mis[w1a] = (w0e && w0a == w1a) ? (w0m | w1m) : w1m;
            end
            m_s1_valid = ego;
            if (ego) begin
                m_s1_mis = hmis;
                m_done[head] = 1'b0; m_mis[head] = 1'b0;
                head = (head + 1) % BOB_COUNT;
                count--;
            end
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every presented entry must match the oldest expected retire, on time.
    always @(negedge clk) begin
        if (!rst) begin
            if (ret_valid) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL ret_spurious: got ret_addr %0d expected no entry (cycle %0d)", ret_addr, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("ret_addr", 64'(ret_addr), 64'(e.addr));
                    chk("ret_data", 64'(ret_data), 64'(e.data));
                    chk("ret_mispred", 64'(ret_mispred), 64'(e.mis));
                    chk("ret_timing", 64'(cyc), 64'(e.due));
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                exp_t e;
                e = q.pop_front();
                total++; bad++;
                $display("FAIL ret_missing: got no entry expected addr %0d (cycle %0d)", e.addr, cyc);
            end
        end
    end

    initial begin
        bit w0e, w1e, w0m, w1m;
        int w0a, w1a, a;
        total = 0; bad = 0; cyc = 0; head = 0; count = 0;
        m_s1_valid = 1'b0; m_s1_mis = 1'b0;
        foreach (m_done[i]) begin m_done[i] = 1'b0; m_mis[i] = 1'b0; end
        foreach (mem[i]) mem[i] = {8'($urandom), 32'($urandom)};
        rst = 1'b1; except_in = 1'b0; hasRetire = 1'b0; retire_addr = '0;
        done0_en = 1'b0; done0_addr = '0; done0_mispred = 1'b0;
        done1_en = 1'b0; done1_addr = '0; done1_mispred = 1'b0; ret_stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_doRetire", 64'(doRetire), 64'd0);
        chk("rst_clkEn", 64'(ram_read_clkEn), 64'd0);
        chk("rst_ret_valid", 64'(ret_valid), 64'd0);
        chk("rst_ret_addr", 64'(ret_addr), 64'd0);
        chk("rst_ret_data", 64'(ret_data), 64'd0);
        chk("rst_ret_mispred", 64'(ret_mispred), 64'd0);
        chk("rst_flush", 64'(flush), 64'd0);
        rst = 1'b0;
        @(posedge clk); cyc++;

        idle(10);
        head = 5;  count = 1; step(1, 5, 0, 0, 0, 0, 0, 0); idle(3);
        head = 46; count = 3; step(1, 47, 0, 1, 0, 0, 0, 0); step(1, 46, 0, 0, 0, 0, 0, 0); idle(5);
        head = 10; count = 2; step(1, 10, 1, 1, 11, 0, 0, 0); idle(4);
        head = 11; count = 1; idle(3);
        head = 12; count = 1; step(1, 12, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0); step(0, 0, 0, 0, 0, 0, 1, 0); step(0, 0, 0, 0, 0, 0, 1, 0); idle(3);
        head = 20; count = 1; step(1, 20, 0, 1, 20, 1, 0, 0); idle(4);
        head = 30; count = 1; step(1, 30, 0, 0, 0, 0, 1, 0); step(0, 0, 0, 0, 0, 0, 1, 1); idle(2);
        head = 30; count = 1; idle(3);
        head = 40; count = 1; step(1, 52, 1, 0, 0, 0, 0, 0); idle(3);
        count = 0;

        for (int n = 0; n < 600; n++) begin
            if (count < BOB_COUNT && $urandom_range(0, 1) == 1) count++;
            w0e = 0; w0a = 0; w0m = 0; w1e = 0; w1a = 0; w1m = 0;
            if (count > 0 && $urandom_range(0, 2) != 0) begin
                a = (head + int'($urandom_range(0, count - 1))) % BOB_COUNT;
                if (!m_done[a]) begin w0e = 1; w0a = a; w0m = ($urandom_range(0, 7) == 0); end
            end
            if (count > 0 && $urandom_range(0, 2) != 0) begin
                a = (head + int'($urandom_range(0, count - 1))) % BOB_COUNT;
                if (!m_done[a]) begin w1e = 1; w1a = a; w1m = ($urandom_range(0, 7) == 0); end
            end else if ($urandom_range(0, 15) == 0) begin
                w1e = 1; w1a = 48 + int'($urandom_range(0, 15)); w1m = 1;
            end
            step(w0e, w0a, w0m, w1e, w1a, w1m,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0);
        end
        count = 0;
        idle(5);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bob_retire.md
Name: bob_retire

Overview:
- In-order retire reader for the 48-entry branch order buffer (BOB).
- The BOB allocator writes entries and advances the tail; this block consumes from the head.
- Tracks per-entry completion (done/mispredict) from two execution writeback ports, reads the head entry from the BOB RAM, pulses doRetire to advance the head, and presents retired entries downstream.
- On a retired mispredict it raises a one-cycle flush that drives the allocator's except input.

Parameters:
- BOB_COUNT, 48, number of BOB entries; addresses 0..47.
- ADDR_WIDTH, 6, BOB address width.
- DATA_WIDTH, `bob_width, BOB RAM entry width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- except_in  in  1  external exception flush
- hasRetire  in  1  allocator: BOB non-empty
- retire_addr  in  6  allocator: current head address
- doRetire  out  1  pulse: head entry consumed, allocator advances head
- ram_read_clkEn  out  1  BOB RAM read-address register enable
- ram_read_addr  out  6  BOB RAM read address
- ram_read_data  in  DATA_WIDTH  BOB RAM data; valid the cycle after ram_read_clkEn
- done0_en  in  1  writeback port 0 valid
- done0_addr  in  6  writeback port 0 entry
- done0_mispred  in  1  writeback port 0 mispredict flag
- done1_en, done1_addr, done1_mispred  in  1/6/1  writeback port 1, same meaning
- ret_stall  in  1  downstream back-pressure
- ret_valid  out  1  retired-entry output valid, single-cycle
- ret_addr  out  6  BOB address of the retired entry
- ret_data  out  DATA_WIDTH  retired entry contents
- ret_mispred  out  1  retired entry mispredicted
- flush  out  1  one-cycle flush request; drives allocator except

Behaviour:
- State:
  - done[47:0] and mis[47:0] bitmaps.
  - Stage-1 register set: s1_valid, s1_addr, s1_mis.
- Reset:
  - Clears done, mis and s1_valid.
  - All outputs are 0 during and after reset until new activity.
- Writeback, per cycle and per port: done[addr]<=1; mis[addr]<=mispred.
  - Both ports on the same address: done=1, mis=OR of both flags.
  - Address >47 is ignored.
- Stage 0 (issue) condition:
  - go = hasRetire & done[retire_addr] & !ret_stall & !kill.
  - kill = flush | except_in.
- When go is true in the same cycle:
  - doRetire=1, ram_read_clkEn=1.
  - done[retire_addr] and mis[retire_addr] are cleared.
  - s1_valid<=1, s1_addr<=retire_addr, s1_mis<=mis[retire_addr].
- ram_read_addr=retire_addr combinationally in every cycle. ram_read_clkEn is high only when go is true.
- Throughput and latency:
  - At most one retire per cycle, with back-to-back retire allowed.
  - The head advances on the next edge, so the next entry is checked the cycle after.
  - Latency from done write (cycle N) to doRetire is N+1; ret_valid follows at N+2.
- Stage 1 (output): ret_valid=s1_valid, ret_addr=s1_addr, ret_mispred=s1_mis, ret_data=ram_read_data. s1_valid clears the next cycle unless it is reloaded by go.
- Flush:
  - flush = s1_valid & s1_mis, combinational from registers.
  - While flush is high, stage 0 is blocked, so no entry younger than the mispredict retires.
  - Next edge: done and mis are fully cleared and s1_valid is cleared.
  - The allocator resets its count and head from flush.
- except_in:
  - Same clear as flush; blocks stage 0 that cycle.
  - Does not suppress the ret_valid of an entry already in stage 1.
- Priority at an edge, highest first: rst, then flush/except_in clears (these also override same-cycle writebacks), then retire clear of the head entry (overrides a same-cycle writeback to the head, which is a protocol error and should be flagged by an assertion), then writeback set.
- ret_stall only blocks stage 0. An entry already in stage 1 is always presented; the downstream must absorb one entry after asserting stall.
- Wrap-around is owned by the allocator; retire_addr 47 then 0 needs no special handling here.

Decomposition:
- Shared package (struct.sv defines): bob_count=48, bob_addr_width=6, bob_width. Also a mispredict-bit field position within the entry, if one is later stored in the RAM.
- Natural sub-module: bob_done_tbl, holding the 48-entry done/mis bitmaps. It has two set ports, one clear port and a flash-clear input.

Test Plan:
- Reset, then hasRetire=0 and no writebacks -> all outputs 0; no doRetire over 10 cycles.
- Head=5, hasRetire=1, done0 writes addr 5 (mispred=0) at cycle N -> doRetire at N+1; ret_valid=1, ret_addr=5, ret_data=RAM[5] at N+2; flush=0.
- Entries 46, 47, 0 all done, head=46 -> doRetire on 3 consecutive cycles; ret_addr sequence 46, 47, 0.
- Entries 10 and 11 done, 10 mispredicted -> ret_valid for 10 with ret_mispred=1 and flush=1 in the same cycle. Entry 11 is never retired, and done[11] reads 0 afterwards.
- Head done while ret_stall=1 for 3 cycles -> no doRetire; retire occurs the cycle after stall drops.
- Both ports write addr 20 (mispred 0/1) in the same cycle -> retiring 20 gives ret_mispred=1. except_in pulsed with 30 done -> 30 is never retired.
